// File: rtl/cnu_min_stream.sv
// ---------------------------------------------------------------------------
// cnu_min_stream
//
// Streaming min-sum check-node front end. Sign-magnitude messages arrive P
// lanes per beat. A frame has a variable number of beats and ends on in_last,
// or when it reaches DMAX entries. For each frame the block reports:
//   - the smallest magnitude (min) and the global index of that entry (min_idx)
//   - the second-smallest magnitude (min2)
//   - the XOR of the signs (sgn)
//   - the number of enabled lanes (cnt)
//   - whether the frame was closed at DMAX without in_last (err)
//
// Ports
//   clk, rst     rising-edge clock, asynchronous active-low reset
//   in_valid     input beat valid
//   in_ready     input beat accepted when in_valid && in_ready
//   in_data      P lanes of (data_w+1) bits; lane k at [(data_w+1)*k +: data_w+1]
//   in_mask      per-lane enable; a masked lane is ignored entirely
//   in_last      final beat of the frame
//   out_valid    result valid
//   out_ready    result consumed when out_valid && out_ready
//   min, min2, min_idx, sgn, cnt, err   registered per-frame result
// ---------------------------------------------------------------------------
module cnu_min_stream #(
    parameter int data_w = 8,
    parameter int idx_w  = 8,
    parameter int P      = 4,
    parameter int DMAX   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [(data_w+1)*P-1:0] in_data,
    input  logic [P-1:0]            in_mask,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [data_w-1:0]       min,
    output logic [data_w-1:0]       min2,
    output logic [idx_w-1:0]        min_idx,
    output logic                    sgn,
    output logic [idx_w:0]          cnt,
    output logic                    err
);

    localparam int BEATS = DMAX / P;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BW-1:0]     LAST_BEAT = BW'(BEATS - 1);
    localparam logic [BW-1:0]     BEAT_ONE  = BW'(1);
    localparam logic [idx_w:0]    CNT_ONE   = (idx_w+1)'(1);
    localparam logic [data_w-1:0] MAG_MAX   = '1;

    // Accumulator for the frame in progress
    logic [data_w-1:0] acc_min_q, acc_min_d;
    logic [data_w-1:0] acc_min2_q, acc_min2_d;
    logic [idx_w-1:0]  acc_idx_q, acc_idx_d;
    logic              acc_sgn_q, acc_sgn_d;
    logic [idx_w:0]    acc_cnt_q, acc_cnt_d;
    logic [BW-1:0]     beat_q, beat_d;

    // Output registers
    logic              out_valid_q, out_valid_d;
    logic [data_w-1:0] min_q, min_d;
    logic [data_w-1:0] min2_q, min2_d;
    logic [idx_w-1:0]  min_idx_q, min_idx_d;
    logic              sgn_q, sgn_d;
    logic [idx_w:0]    cnt_q, cnt_d;
    logic              err_q, err_d;

    // Merge results for the current beat combined with the accumulator
    logic [data_w-1:0] mrg_min, mrg_min2, lane_mag;
    logic [idx_w-1:0]  mrg_idx, lane_idx;
    logic              mrg_sgn;
    logic [idx_w:0]    mrg_cnt;
    logic              accept, close_frame, forced_close;

    // Only out_valid/out_ready feed in_ready, so there is no path from in_valid.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Lanes are folded in ascending global index order, so a strict compare
    // keeps the earlier entry as min on a tie and the equal value drops into
    // min2. The first enabled entry of a frame always becomes min, which keeps
    // min_idx correct even when that entry is the all-ones magnitude.
    always_comb begin
        mrg_min  = acc_min_q;
        mrg_min2 = acc_min2_q;
        mrg_idx  = acc_idx_q;
        mrg_sgn  = acc_sgn_q;
        mrg_cnt  = acc_cnt_q;
        lane_mag = '0;
        lane_idx = '0;
        for (int k = 0; k < P; k++) begin
            if (in_mask[k]) begin
                lane_mag = in_data[(data_w+1)*k +: data_w];
                lane_idx = idx_w'(int'(beat_q) * P + k);
                if (mrg_cnt == '0 || lane_mag < mrg_min) begin
                    mrg_min2 = mrg_min;
                    mrg_min  = lane_mag;
                    mrg_idx  = lane_idx;
                end else if (lane_mag < mrg_min2) begin
                    mrg_min2 = lane_mag;
                end
                mrg_sgn = mrg_sgn ^ in_data[(data_w+1)*k + data_w];
                mrg_cnt = mrg_cnt + CNT_ONE;
            end
        end
    end

    // A frame closes on in_last, or is force-closed on its final permitted beat.
    always_comb begin
        forced_close = !in_last && (beat_q == LAST_BEAT);
        close_frame  = in_last || (beat_q == LAST_BEAT);
    end

    // Next-state for accumulator and output registers. Closing a frame loads
    // the outputs and re-arms the accumulator on the same edge, so the next
    // frame can start without a bubble.
    always_comb begin
        acc_min_d   = acc_min_q;
        acc_min2_d  = acc_min2_q;
        acc_idx_d   = acc_idx_q;
        acc_sgn_d   = acc_sgn_q;
        acc_cnt_d   = acc_cnt_q;
        beat_d      = beat_q;
        out_valid_d = out_valid_q;
        min_d       = min_q;
        min2_d      = min2_q;
        min_idx_d   = min_idx_q;
        sgn_d       = sgn_q;
        cnt_d       = cnt_q;
        err_d       = err_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (close_frame) begin
                out_valid_d = 1'b1;
                min_d       = mrg_min;
                min2_d      = mrg_min2;
                min_idx_d   = mrg_idx;
                sgn_d       = mrg_sgn;
                cnt_d       = mrg_cnt;
                err_d       = forced_close;
                acc_min_d   = MAG_MAX;
                acc_min2_d  = MAG_MAX;
                acc_idx_d   = '0;
                acc_sgn_d   = 1'b0;
                acc_cnt_d   = '0;
                beat_d      = '0;
            end else begin
                acc_min_d  = mrg_min;
                acc_min2_d = mrg_min2;
                acc_idx_d  = mrg_idx;
                acc_sgn_d  = mrg_sgn;
                acc_cnt_d  = mrg_cnt;
                beat_d     = beat_q + BEAT_ONE;
            end
        end
    end

    // State registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_min_q   <= MAG_MAX;
            acc_min2_q  <= MAG_MAX;
            acc_idx_q   <= '0;
            acc_sgn_q   <= 1'b0;
            acc_cnt_q   <= '0;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
            min_q       <= '0;
            min2_q      <= '0;
            min_idx_q   <= '0;
            sgn_q       <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            acc_min_q   <= acc_min_d;
            acc_min2_q  <= acc_min2_d;
            acc_idx_q   <= acc_idx_d;
            acc_sgn_q   <= acc_sgn_d;
            acc_cnt_q   <= acc_cnt_d;
            beat_q      <= beat_d;
            out_valid_q <= out_valid_d;
            min_q       <= min_d;
            min2_q      <= min2_d;
            min_idx_q   <= min_idx_d;
            sgn_q       <= sgn_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign min       = min_q;
    assign min2      = min2_q;
    assign min_idx   = min_idx_q;
    assign sgn       = sgn_q;
    assign cnt       = cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cnu_min_stream.sv
// ---------------------------------------------------------------------------
// tb_cnu_min_stream
//
// Drives cnu_min_stream with directed frames and randomized traffic
// (random masks, magnitudes, frame lengths, input bubbles and output
// back-pressure). A reference model keeps the entries of the open frame in
// queues and derives each frame result from plain minimum searches. Expected
// results wait in a queue until the DUT presents them.
// ---------------------------------------------------------------------------
module tb_cnu_min_stream;

    localparam int DW    = 8;
    localparam int IW    = 8;
    localparam int P     = 4;
    localparam int DMAX  = 32;
    localparam int DATAW = (DW + 1) * P;

    typedef struct {
        logic [DW-1:0] mn;
        logic [DW-1:0] mn2;
        logic [IW-1:0] idx;
        logic          sg;
        logic [IW:0]   cnt;
        logic          er;
    } result_t;

    logic             clk;
    logic             rst;
    logic             inValid;
    logic             inReady;
    logic [DATAW-1:0] inData;
    logic [P-1:0]     inMask;
    logic             inLast;
    logic             outValid;
    logic             outReady;
    logic [DW-1:0]    outMin;
    logic [DW-1:0]    outMin2;
    logic [IW-1:0]    outMinIdx;
    logic             outSgn;
    logic [IW:0]      outCnt;
    logic             outErr;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model state
    int      magQ[$];
    bit      sgnQ[$];
    int      idxQ[$];
    int      beatCount = 0;
    result_t expQ[$];

    cnu_min_stream #(
        .data_w(DW),
        .idx_w (IW),
        .P     (P),
        .DMAX  (DMAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (inValid),
        .in_ready (inReady),
        .in_data  (inData),
        .in_mask  (inMask),
        .in_last  (inLast),
        .out_valid(outValid),
        .out_ready(outReady),
        .min      (outMin),
        .min2     (outMin2),
        .min_idx  (outMinIdx),
        .sgn      (outSgn),
        .cnt      (outCnt),
        .err      (outErr)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Frame result from the collected entries: min is the smallest value at
    // its lowest index, min2 the smallest of all remaining entries.
    function automatic result_t computeResult(input bit er);
        result_t r;
        int best;
        r.mn  = '1;
        r.mn2 = '1;
        r.idx = '0;
        r.sg  = 1'b0;
        r.cnt = (IW+1)'(magQ.size());
        r.er  = er;
        best  = -1;
        foreach (magQ[i]) begin
            r.sg = r.sg ^ sgnQ[i];
            if (best < 0 || magQ[i] < magQ[best]) best = i;
        end
        if (best >= 0) begin
            r.mn  = DW'(magQ[best]);
            r.idx = IW'(idxQ[best]);
            foreach (magQ[i]) begin
                if (i != best && magQ[i] < int'(r.mn2)) r.mn2 = DW'(magQ[i]);
            end
        end
        return r;
    endfunction

    function automatic logic [DATAW-1:0] packBeat(input int m0, input int m1, input int m2, input int m3,
                                                  input logic [P-1:0] signs);
        logic [DATAW-1:0] d;
        d = '0;
        d[0*(DW+1) +: DW] = DW'(m0);
        d[1*(DW+1) +: DW] = DW'(m1);
        d[2*(DW+1) +: DW] = DW'(m2);
        d[3*(DW+1) +: DW] = DW'(m3);
        for (int k = 0; k < P; k++) d[k*(DW+1) + DW] = signs[k];
        return d;
    endfunction

    // One clock cycle: drive inputs after the falling edge, then check the
    // outputs and advance the model before the next rising edge.
    task automatic applyStimulus(input bit v, input logic [DATAW-1:0] data, input logic [P-1:0] mask,
                                 input bit last, input bit ordy, output bit accepted);
        result_t e;
        bit closeNow;
        @(negedge clk);
        inValid  = v;
        inData   = data;
        inMask   = mask;
        inLast   = last;
        outReady = ordy;
        #1;
        checkOutput("out_valid", outValid, expQ.size() != 0);
        checkOutput("in_ready", inReady, (expQ.size() == 0) || ordy);
        if (expQ.size() != 0) begin
            e = expQ[0];
            checkOutput("min", outMin, e.mn);
            checkOutput("min2", outMin2, e.mn2);
            checkOutput("min_idx", outMinIdx, e.idx);
            checkOutput("sgn", outSgn, e.sg);
            checkOutput("cnt", outCnt, e.cnt);
            checkOutput("err", outErr, e.er);
            if (ordy) void'(expQ.pop_front());
        end
        accepted = v && ((expQ.size() == 0) || ordy || e.er === 1'bx);
        // Acceptance follows the handshake rule on the model's own view.
        accepted = v && ((outValid === 1'b0 && expQ.size() == 0) || ordy);
        if (accepted) begin
            for (int k = 0; k < P; k++) begin
                if (mask[k]) begin
                    magQ.push_back(int'(data[k*(DW+1) +: DW]));
                    sgnQ.push_back(data[k*(DW+1) + DW]);
                    idxQ.push_back(beatCount * P + k);
                end
            end
            closeNow = last || (beatCount == DMAX / P - 1);
            if (closeNow) begin
                expQ.push_back(computeResult(!last));
                magQ.delete();
                sgnQ.delete();
                idxQ.delete();
                beatCount = 0;
            end else begin
                beatCount++;
            end
        end
    endtask

    // Retries one beat until accepted, within a bounded number of cycles.
    task automatic sendBeat(input logic [DATAW-1:0] data, input logic [P-1:0] mask, input bit last,
                            input bit randomReady);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 200) begin
            applyStimulus(1'b1, data, mask, last, randomReady ? ($urandom_range(0, 2) != 0) : 1'b1, acc);
            tries++;
        end
        if (!acc) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic idleCycles(input int n);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, acc);
    endtask

    initial begin
        bit acc;
        logic [DATAW-1:0] d;
        logic [P-1:0] m;
        int nb;
        int smallRange;

        rst      = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        inMask   = '0;
        inLast   = 1'b0;
        outReady = 1'b0;

        #2;
        checkOutput("reset_out_valid", outValid, 0);
        checkOutput("reset_min", outMin, 0);
        checkOutput("reset_min2", outMin2, 0);
        checkOutput("reset_min_idx", outMinIdx, 0);
        checkOutput("reset_sgn", outSgn, 0);
        checkOutput("reset_cnt", outCnt, 0);
        checkOutput("reset_err", outErr, 0);
        @(negedge clk);
        rst = 1'b1;

        // Single beat with a tie between lanes 1 and 3
        sendBeat(packBeat(5, 3, 9, 3, 4'b1010), 4'b1111, 1'b1, 1'b0);
        // Two-beat frame, minimum in the second beat
        sendBeat(packBeat(7, 6, 8, 9, 4'b0000), 4'b1111, 1'b0, 1'b0);
        sendBeat(packBeat(2, 10, 4, 11, 4'b0001), 4'b1111, 1'b1, 1'b0);
        // Single enabled lane, and an empty frame
        sendBeat(packBeat(1, 1, 6, 1, 4'b0100), 4'b0100, 1'b1, 1'b0);
        sendBeat(packBeat(3, 3, 3, 3, 4'b1111), 4'b0000, 1'b1, 1'b0);
        // Lone all-ones entry in a non-zero lane
        sendBeat(packBeat(0, 0, 255, 0, 4'b0000), 4'b0100, 1'b1, 1'b0);
        // Force-close at DMAX, then a short frame that restarts at index 0
        for (int b = 0; b < DMAX / P; b++)
            sendBeat(packBeat(20 + b, 30, 40, 50 - b, 4'b0011), 4'b1111, 1'b0, 1'b0);
        sendBeat(packBeat(9, 8, 7, 6, 4'b0000), 4'b1111, 1'b1, 1'b0);
        idleCycles(2);

        // Back-pressure: result held for 5 cycles while a last beat waits
        sendBeat(packBeat(4, 12, 13, 14, 4'b0001), 4'b1111, 1'b1, 1'b0);
        d = packBeat(50, 40, 60, 45, 4'b0110);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, d, 4'b1111, 1'b1, 1'b0, acc);
            checkOutput("stall_no_accept", acc, 0);
        end
        applyStimulus(1'b1, d, 4'b1111, 1'b1, 1'b1, acc);
        checkOutput("stall_release_accept", acc, 1);
        idleCycles(2);

        // Reset in the middle of a frame discards it
        sendBeat(packBeat(0, 0, 0, 0, 4'b0000), 4'b1111, 1'b0, 1'b0);
        sendBeat(packBeat(0, 0, 0, 0, 4'b0000), 4'b1111, 1'b0, 1'b0);
        @(negedge clk);
        inValid = 1'b0;
        rst     = 1'b0;
        #1;
        checkOutput("midreset_out_valid", outValid, 0);
        checkOutput("midreset_min", outMin, 0);
        checkOutput("midreset_cnt", outCnt, 0);
        checkOutput("midreset_err", outErr, 0);
        magQ.delete();
        sgnQ.delete();
        idxQ.delete();
        expQ.delete();
        beatCount = 0;
        @(negedge clk);
        rst = 1'b1;
        sendBeat(packBeat(1, 1, 1, 1, 4'b0000), 4'b1111, 1'b1, 1'b0);
        idleCycles(2);

        // Randomized traffic with bubbles and random back-pressure
        for (int f = 0; f < 60; f++) begin
            nb = $urandom_range(1, 10);
            smallRange = $urandom_range(0, 1);
            for (int b = 0; b < nb; b++) begin
                m = P'($urandom);
                if ($urandom_range(0, 7) == 0) m = '0;
                for (int k = 0; k < P; k++) begin
                    d[k*(DW+1) +: DW] = smallRange ? DW'($urandom_range(0, 5))
                                                   : DW'($urandom_range(0, 255));
                    if ($urandom_range(0, 15) == 0) d[k*(DW+1) +: DW] = '1;
                    d[k*(DW+1) + DW] = 1'($urandom);
                end
                if ($urandom_range(0, 3) == 0)
                    applyStimulus(1'b0, d, m, 1'b0, $urandom_range(0, 1) != 0, acc);
                sendBeat(d, m, b == nb - 1, 1'b1);
            end
        end

        // Drain remaining results
        for (int i = 0; i < 20 && expQ.size() != 0; i++)
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, acc);
        checkOutput("drain_empty", expQ.size(), 0);
        idleCycles(1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        nFails++;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
